hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 1, giving the number of cycles isBranchPredictMiss stays high per mispredict (legal range 1..15).
REQ-002 The block SHALL have parameter STALL_CYCLES, default 1, giving the number of cycles isDataHazard stays high per load-use hazard (legal range 1..15).
REQ-003 Ports SHALL be exactly:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- decRs1 / decRs2  in  5 each  decode-stage source register numbers
- decRs1Used / decRs2Used  in  1 each  source operand actually read
- exRd  in  5  execute-stage destination register
- exRegWrite  in  1  execute-stage instruction writes exRd
- exIsLoad  in  1  execute-stage instruction is a load
- memRd  in  5, memRegWrite  in  1  memory-stage destination and write enable
- wbRd  in  5, wbRegWrite  in  1  writeback-stage destination and write enable
- brResolved  in  1  execute-stage branch resolved this cycle
- brMispredict  in  1  resolved branch was mispredicted (qualified by brResolved)
- isDataHazard  out  1  stall fetch/decode
- isBranchPredictMiss  out  1  flush fetch/decode/execute
- op1BypassCtrl / op2BypassCtrl  out  2 each  BypassCtrl: NONE=0, EX=1, MEM=2, WB=3
- perfStallCnt / perfMissCnt  out  32 each  present only with HAZARD_PERF_CNT_EN

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, STALL, FLUSH, with a 4-bit down-counter cnt.
REQ-005 A mispredict event SHALL be brResolved=1 and brMispredict=1; brMispredict with brResolved=0 SHALL be ignored.
REQ-006 A load-use hazard SHALL be detected when exRegWrite=1, exIsLoad=1, exRd!=0, and (decRs1Used with decRs1==exRd, or decRs2Used with decRs2==exRd).
REQ-007 IDLE + mispredict: next state FLUSH, cnt=FLUSH_CYCLES-1; mispredict SHALL take priority over load-use.
REQ-008 IDLE + load-use, no mispredict: isDataHazard=1 combinationally in the same cycle; if STALL_CYCLES>1, next state STALL with cnt=STALL_CYCLES-2, else remain IDLE.
REQ-009 STALL: isDataHazard=1; cnt decrements; exits to IDLE when cnt==0; a mispredict SHALL transition to FLUSH exactly as in REQ-007.
REQ-010 FLUSH: isBranchPredictMiss=1 (registered output, first asserted the cycle after the event); cnt decrements; exits to IDLE when cnt==0.
REQ-011 During FLUSH, further mispredict events SHALL be ignored, and isDataHazard SHALL be 0.
REQ-012 Bypass selection SHALL be per operand and combinational, with priority EX > MEM > WB.
REQ-013 The EX bypass source SHALL be excluded when exIsLoad=1.
REQ-014 A stage SHALL match only if its write enable is set, its rd equals the source register, and rd!=0; no match SHALL give NONE.
REQ-015 An unused operand (decRsXUsed=0) SHALL select NONE.
REQ-016 Both bypass controls SHALL be NONE while in FLUSH.

Reset
REQ-017 While rst=0, the state SHALL be IDLE, cnt=0, isDataHazard=0, isBranchPredictMiss=0, both bypass controls NONE, and perf counters 0, regardless of other inputs.
REQ-018 Reset asserted mid-STALL or mid-FLUSH SHALL abort immediately; the first cycle after release SHALL behave as IDLE.

Configuration
REQ-019 With macro HAZARD_PERF_CNT_EN defined:
- perfStallCnt SHALL increment every cycle isDataHazard=1.
- perfMissCnt SHALL increment once per accepted mispredict event.
- Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 Without HAZARD_PERF_CNT_EN, the perf ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 Load x5 in EX, decode reads rs1=x5 used, STALL_CYCLES=1 -> isDataHazard=1 for exactly 1 cycle; next cycle op1BypassCtrl=MEM when memRd=5.
REQ-022 exRd=memRd=wbRd=7, all writing, exIsLoad=0, decRs2=7 used -> op2BypassCtrl=EX; with exRegWrite=0 -> MEM; with memRegWrite=0 also -> WB.
REQ-023 exRd=0, exRegWrite=1, decRs1=0 used -> op1BypassCtrl=NONE; load to x0 -> isDataHazard=0.
REQ-024 FLUSH_CYCLES=2, mispredict at cycle N -> isBranchPredictMiss=1 at N+1 and N+2, 0 at N+3; a second mispredict at N+1 is ignored (perfMissCnt=1).
REQ-025 Load-use and mispredict in the same cycle -> FLUSH entered, isDataHazard=0 from N+1 onward, bypass controls NONE during FLUSH.
REQ-026 STALL_CYCLES=3, rst pulled low during the 2nd stall cycle -> isDataHazard=0 immediately; after release with no hazard inputs -> outputs stay 0/NONE.

Source files
------------

// File: rtl/hazard_unit.sv
// Load-use stall, mispredict flush and operand bypass control.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] decRs1,
  input  logic [4:0] decRs2,
  input  logic       decRs1Used,
  input  logic       decRs2Used,
  input  logic [4:0] exRd,
  input  logic       exRegWrite,
  input  logic       exIsLoad,
  input  logic [4:0] memRd,
  input  logic       memRegWrite,
  input  logic [4:0] wbRd,
  input  logic       wbRegWrite,
  input  logic       brResolved,
  input  logic       brMispredict,
  output logic       isDataHazard,
  output logic       isBranchPredictMiss,
  output logic [1:0] op1BypassCtrl,
  output logic [1:0] op2BypassCtrl
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perfStallCnt,
  output logic [31:0] perfMissCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    BP_NONE = 2'd0,
    BP_EX   = 2'd1,
    BP_MEM  = 2'd2,
    BP_WB   = 2'd3
  } bypass_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_INIT =
    (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam bit MULTI_STALL = (STALL_CYCLES > 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       hazard;
  logic       mispredict;
  logic       load_use;
  logic       rs1_hit;
  logic       rs2_hit;
  logic [1:0] sel1;
  logic [1:0] sel2;

  assign mispredict = brResolved & brMispredict;

  assign rs1_hit = decRs1Used & (decRs1 == exRd);
  assign rs2_hit = decRs2Used & (decRs2 == exRd);
  assign load_use = exRegWrite & exIsLoad
                  & (exRd != 5'd0)
                  & (rs1_hit | rs2_hit);

  // Loads have no data in EX yet, so EX is never a bypass source for them.
  function automatic logic [1:0] bypass_sel(
    input logic       used,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = BP_NONE;
    if (!used || rs == 5'd0) begin
      sel = BP_NONE;
    end else if (exRegWrite && !exIsLoad && exRd == rs) begin
      sel = BP_EX;
    end else if (memRegWrite && memRd == rs) begin
      sel = BP_MEM;
    end else if (wbRegWrite && wbRd == rs) begin
      sel = BP_WB;
    end
    return sel;
  endfunction

  assign sel1 = bypass_sel(decRs1Used, decRs1);
  assign sel2 = bypass_sel(decRs2Used, decRs2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hazard  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mispredict) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_INIT;
        end else if (load_use) begin
          hazard = 1'b1;
          if (MULTI_STALL) begin
            state_n = STALL;
            cnt_n   = STALL_INIT;
          end
        end
      end
      STALL: begin
        hazard = 1'b1;
        if (mispredict) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_INIT;
        end else if (cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Gate with rst so combinational outputs are quiet during reset.
  assign isDataHazard        = rst & hazard;
  assign isBranchPredictMiss = (state == FLUSH);
  assign op1BypassCtrl = (rst && state != FLUSH) ? sel1 : BP_NONE;
  assign op2BypassCtrl = (rst && state != FLUSH) ? sel2 : BP_NONE;

`ifdef HAZARD_PERF_CNT_EN
  logic miss_accept;

  assign miss_accept = mispredict & (state != FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfStallCnt <= 32'd0;
      perfMissCnt  <= 32'd0;
    end else begin
      if (isDataHazard) perfStallCnt <= perfStallCnt + 32'd1;
      if (miss_accept)  perfMissCnt  <= perfMissCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: two instances (STALL=3/FLUSH=2 and STALL=1/FLUSH=1)
// share stimulus; expected outputs are queued per cycle.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] decRs1, decRs2;
  logic       decRs1Used, decRs2Used;
  logic [4:0] exRd, memRd, wbRd;
  logic       exRegWrite, exIsLoad, memRegWrite, wbRegWrite;
  logic       brResolved, brMispredict;

  logic       dh_a, bpm_a, dh_b, bpm_b;
  logic [1:0] o1_a, o2_a, o1_b, o2_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps_a, pm_a, ps_b, pm_b;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.FLUSH_CYCLES(2), .STALL_CYCLES(3)) u_a (
    .clk(clk), .rst(rst),
    .decRs1(decRs1), .decRs2(decRs2),
    .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
    .exRd(exRd), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
    .memRd(memRd), .memRegWrite(memRegWrite),
    .wbRd(wbRd), .wbRegWrite(wbRegWrite),
    .brResolved(brResolved), .brMispredict(brMispredict),
    .isDataHazard(dh_a), .isBranchPredictMiss(bpm_a),
    .op1BypassCtrl(o1_a), .op2BypassCtrl(o2_a)
`ifdef HAZARD_PERF_CNT_EN
    , .perfStallCnt(ps_a), .perfMissCnt(pm_a)
`endif
  );

  hazard_unit #(.FLUSH_CYCLES(1), .STALL_CYCLES(1)) u_b (
    .clk(clk), .rst(rst),
    .decRs1(decRs1), .decRs2(decRs2),
    .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
    .exRd(exRd), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
    .memRd(memRd), .memRegWrite(memRegWrite),
    .wbRd(wbRd), .wbRegWrite(wbRegWrite),
    .brResolved(brResolved), .brMispredict(brMispredict),
    .isDataHazard(dh_b), .isBranchPredictMiss(bpm_b),
    .op1BypassCtrl(o1_b), .op2BypassCtrl(o2_b)
`ifdef HAZARD_PERF_CNT_EN
    , .perfStallCnt(ps_b), .perfMissCnt(pm_b)
`endif
  );

  typedef struct {
    logic        dh, bpm;
    logic [1:0]  o1, o2;
    logic        dhb, bpmb;
    logic [1:0]  o1b, o2b;
    logic        pc;
    logic [31:0] ps, pm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic        pend_pc = 1'b0;
  logic [31:0] pend_ps = 0, pend_pm = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a_dh",  32'(dh_a),  32'(e.dh));
      chk("a_bpm", 32'(bpm_a), 32'(e.bpm));
      chk("a_op1", 32'(o1_a),  32'(e.o1));
      chk("a_op2", 32'(o2_a),  32'(e.o2));
      chk("b_dh",  32'(dh_b),  32'(e.dhb));
      chk("b_bpm", 32'(bpm_b), 32'(e.bpmb));
      chk("b_op1", 32'(o1_b),  32'(e.o1b));
      chk("b_op2", 32'(o2_b),  32'(e.o2b));
`ifdef HAZARD_PERF_CNT_EN
      if (e.pc) begin
        chk("a_perf_stall", ps_a, e.ps);
        chk("a_perf_miss",  pm_a, e.pm);
      end
`endif
    end
  end

  task automatic push(input logic dh, input logic bpm,
                      input logic [1:0] o1, input logic [1:0] o2,
                      input logic dhb, input logic bpmb,
                      input logic [1:0] o1b, input logic [1:0] o2b);
    exp_t x;
    x.dh = dh; x.bpm = bpm; x.o1 = o1; x.o2 = o2;
    x.dhb = dhb; x.bpmb = bpmb; x.o1b = o1b; x.o2b = o2b;
    x.pc = pend_pc; x.ps = pend_ps; x.pm = pend_pm;
    pend_pc = 1'b0;
    q.push_back(x);
  endtask

  task automatic perf(input logic [31:0] s, input logic [31:0] m);
    pend_pc = 1'b1;
    pend_ps = s;
    pend_pm = m;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    decRs1 = 0; decRs2 = 0; decRs1Used = 0; decRs2Used = 0;
    exRd = 0; exRegWrite = 0; exIsLoad = 0;
    memRd = 0; memRegWrite = 0; wbRd = 0; wbRegWrite = 0;
    brResolved = 0; brMispredict = 0;
  endtask

  task automatic load_use5();
    exRd = 5; exRegWrite = 1; exIsLoad = 1;
    decRs1 = 5; decRs1Used = 1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    // reset holds everything quiet despite active hazard inputs
    nxt(); load_use5(); brResolved = 1; brMispredict = 1;
    perf(0, 0); push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); memRd = 5; memRegWrite = 1; decRs2 = 5; decRs2Used = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); rst = 1'b1; clr();
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // bypass priority EX > MEM > WB
    nxt(); clr();
    exRd = 7; memRd = 7; wbRd = 7;
    exRegWrite = 1; memRegWrite = 1; wbRegWrite = 1;
    decRs2 = 7; decRs2Used = 1;
    push(0, 0, 0, 1, 0, 0, 0, 1);
    nxt(); exRegWrite = 0;
    push(0, 0, 0, 2, 0, 0, 0, 2);
    nxt(); memRegWrite = 0; decRs1 = 7; decRs1Used = 1;
    push(0, 0, 3, 3, 0, 0, 3, 3);
    nxt(); wbRegWrite = 0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // unused operand
    nxt(); clr(); exRd = 7; exRegWrite = 1; decRs1 = 7;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // x0 never bypassed nor stalls
    nxt(); clr(); exRegWrite = 1; decRs1Used = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); exIsLoad = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: A stalls 3 cycles, B one
    nxt(); clr(); load_use5();
    push(1, 0, 0, 0, 1, 0, 0, 0);
    nxt(); clr(); memRd = 5; memRegWrite = 1; decRs1 = 5; decRs1Used = 1;
    push(1, 0, 2, 0, 0, 0, 2, 0);
    nxt();
    push(1, 0, 2, 0, 0, 0, 2, 0);
    nxt(); clr(); perf(3, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // unqualified mispredict is ignored
    nxt(); brMispredict = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); clr();
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // mispredict with load-use, repeated next cycle
    nxt(); clr(); load_use5();
    memRd = 6; memRegWrite = 1; decRs2 = 6; decRs2Used = 1;
    brResolved = 1; brMispredict = 1;
    push(0, 0, 0, 2, 0, 0, 0, 2);
    nxt();
    push(0, 1, 0, 0, 0, 1, 0, 0);
    nxt(); clr();
    push(0, 1, 0, 0, 0, 0, 0, 0);
    nxt(); perf(3, 1);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // mispredict arriving during a stall
    nxt(); clr(); load_use5();
    push(1, 0, 0, 0, 1, 0, 0, 0);
    nxt(); clr(); brResolved = 1; brMispredict = 1;
    push(1, 0, 0, 0, 0, 0, 0, 0);
    nxt(); clr();
    push(0, 1, 0, 0, 0, 1, 0, 0);
    nxt();
    push(0, 1, 0, 0, 0, 0, 0, 0);
    nxt(); perf(5, 2);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    // reset during the second stall cycle
    nxt(); clr(); load_use5();
    push(1, 0, 0, 0, 1, 0, 0, 0);
    nxt(); rst = 1'b0; perf(0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); rst = 1'b1; clr();
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); perf(0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
    push(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
